conv_pe_acc: RTL

- Parametrised successor of the 3x3x3 conv processing element for the systolic conv array.
- Computes a signed K-tap, C-channel dot product per valid beat and accumulates across input-channel tiles, so layers deeper than C channels run on one PE.
- Requantises the result with round, shift, optional ReLU and saturate.
- Forwards the moving operand to the next PE in the row.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv_dot.sv | 48 ++++
 rtl/conv_pe_acc.sv | 133 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared width helpers, operand packing and saturation bounds
// for the conv processing element.
package conv_pkg;

  function automatic int prod_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int dot_w(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  // Channel 0 and tap 0 sit in the MSBs of a packed operand.
  function automatic int slice_lsb(
    input int ch,
    input int tap,
    input int k,
    input int c,
    input int dw
  );
    return ((c - ch) * k - tap - 1) * dw;
  endfunction

  function automatic longint round_bias(input int sh);
    if (sh > 0) return longint'(1) <<< (sh - 1);
    return longint'(0);
  endfunction

  function automatic longint sat_max(input int ow);
    return (longint'(1) <<< (ow - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int ow);
    return -(longint'(1) <<< (ow - 1));
  endfunction

endpackage

// File: rtl/conv_dot.sv
// One-channel signed K-tap dot product: registered products,
// then registered sum.
module conv_dot
  import conv_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int KERNEL_SIZE = 9,
  localparam int PW = prod_w(DATA_W),
  localparam int DW = dot_w(DATA_W, KERNEL_SIZE)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [KERNEL_SIZE*DATA_W-1:0] in_a_i,
  input  logic [KERNEL_SIZE*DATA_W-1:0] in_b_i,
  output logic signed [DW-1:0]          out_dot_o
);

  logic signed [PW-1:0] r_prod [KERNEL_SIZE];
  logic signed [DW-1:0] r_dot;
  logic signed [DW-1:0] w_sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < KERNEL_SIZE; k++) r_prod[k] <= '0;
    end else begin
      for (int k = 0; k < KERNEL_SIZE; k++) begin
        r_prod[k] <=
          $signed(in_a_i[slice_lsb(0, k, KERNEL_SIZE, 1, DATA_W) +: DATA_W]) *
          $signed(in_b_i[slice_lsb(0, k, KERNEL_SIZE, 1, DATA_W) +: DATA_W]);
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < KERNEL_SIZE; k++) begin
      w_sum = w_sum + DW'(r_prod[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_dot <= '0;
    else       r_dot <= w_sum;
  end

  assign out_dot_o = r_dot;

endmodule

// File: rtl/conv_pe_acc.sv
// Conv PE: multi-channel dot product, tile accumulator,
// round/shift/ReLU/saturate requant and operand forwarding.
module conv_pe_acc
  import conv_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int CHANNELS    = 3,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 8,
  parameter int SHIFT       = 0,
  parameter int RELU_EN     = 0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   in_valid_i,
  input  logic                                   in_first_i,
  input  logic                                   in_last_i,
  input  logic [CHANNELS*KERNEL_SIZE*DATA_W-1:0] in_a_i,
  input  logic [CHANNELS*KERNEL_SIZE*DATA_W-1:0] in_b_i,
  output logic [CHANNELS*KERNEL_SIZE*DATA_W-1:0] out_a_o,
  output logic                                   out_a_valid_o,
  output logic                                   out_valid_o,
  output logic signed [OUT_W-1:0]                out_c_o
);

  localparam int DW = dot_w(DATA_W, KERNEL_SIZE);
  localparam int CW = KERNEL_SIZE * DATA_W;

  localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(round_bias(SHIFT));
  localparam logic signed [ACC_W:0] SMAX = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] SMIN = (ACC_W+1)'(sat_min(OUT_W));

  logic signed [DW-1:0]    w_dot [CHANNELS];
  logic signed [ACC_W-1:0] w_csum;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shf;
  logic signed [ACC_W:0]   w_rel;
  logic signed [OUT_W-1:0] w_rq;

  logic r_v1, r_f1, r_l1;
  logic r_v2, r_f2, r_l2;
  logic r_v3, r_f3, r_l3;
  logic r_lst;
  logic signed [ACC_W-1:0] r_sum;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_res;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int LSB = slice_lsb(c, KERNEL_SIZE - 1,
                                   KERNEL_SIZE, CHANNELS, DATA_W);
    conv_dot #(
      .DATA_W      (DATA_W),
      .KERNEL_SIZE (KERNEL_SIZE)
    ) u_dot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_a_i    (in_a_i[LSB +: CW]),
      .in_b_i    (in_b_i[LSB +: CW]),
      .out_dot_o (w_dot[c])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_a_valid_o <= 1'b0;
      out_a_o       <= '0;
    end else begin
      out_a_valid_o <= in_valid_i;
      if (in_valid_i) out_a_o <= in_a_i;
    end
  end

  // Flags are qualified by valid so idle-cycle flags never reach the acc.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      {r_v1, r_f1, r_l1} <= '0;
      {r_v2, r_f2, r_l2} <= '0;
      {r_v3, r_f3, r_l3} <= '0;
    end else begin
      {r_v1, r_f1, r_l1} <= {in_valid_i,
                             in_valid_i & in_first_i,
                             in_valid_i & in_last_i};
      {r_v2, r_f2, r_l2} <= {r_v1, r_f1, r_l1};
      {r_v3, r_f3, r_l3} <= {r_v2, r_f2, r_l2};
    end
  end

  always_comb begin
    w_csum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_csum = w_csum + {{(ACC_W-DW){w_dot[c][DW-1]}}, w_dot[c]};
    end
  end

  assign w_acc_next = r_f3 ? r_sum : r_acc + r_sum;

  // Channel sum is registered so the accumulator adder sees a short path.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sum <= '0;
      r_acc <= '0;
      r_res <= '0;
      r_lst <= 1'b0;
    end else begin
      r_sum <= w_csum;
      r_lst <= r_v3 & r_l3;
      if (r_v3) r_acc <= w_acc_next;
      if (r_v3 && r_l3) r_res <= w_acc_next;
    end
  end

  always_comb begin
    w_rnd = {r_res[ACC_W-1], r_res} + RND;
    w_shf = w_rnd >>> SHIFT;
    w_rel = (RELU_EN != 0 && w_shf < 0) ? '0 : w_shf;
    if (w_rel > SMAX)      w_rq = SMAX[OUT_W-1:0];
    else if (w_rel < SMIN) w_rq = SMIN[OUT_W-1:0];
    else                   w_rq = w_rel[OUT_W-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_c_o     <= '0;
    end else begin
      out_valid_o <= r_lst;
      if (r_lst) out_c_o <= w_rq;
    end
  end

endmodule
